// File: rtl/alu_writeback_stage.sv
// Writeback stage: 2-entry in-order queue between the ALU and the register file.
// Commits results, maintains carry/zero flags and resolves equality branches.
module alu_writeback_stage #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [19:0] in_s,
    input  logic        in_cout,
    input  logic        in_e,
    input  logic [2:0]  in_op,
    input  logic        in_wb,
    input  logic [3:0]  in_dest,
    input  logic        in_branch,
    input  logic [19:0] in_target,
    input  logic        rf_ready,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [19:0] rf_wdata,
    output logic        flag_c,
    output logic        flag_z,
    output logic        branch_taken,
    output logic [19:0] branch_pc,
    output logic [15:0] retire_count
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    typedef struct packed {
        logic [19:0] s;
        logic        cout;
        logic        e;
        logic [2:0]  op;
        logic        wb;
        logic [3:0]  dest;
        logic        branch;
        logic [19:0] target;
    } entry_t;

    entry_t      slot0_q, slot0_d, slot1_q, slot1_d, in_ent;
    logic [1:0]  count_q, count_d;
    logic        flag_c_q, flag_c_d, flag_z_q, flag_z_d;
    logic [15:0] retire_q, retire_d;
    logic        head_valid, commit, taken, accept;

    assign in_ready     = (count_q < FULL);
    assign head_valid   = (count_q != 2'd0);
    assign rf_we        = head_valid & slot0_q.wb & ~slot0_q.branch;
    assign rf_waddr     = slot0_q.dest;
    assign rf_wdata     = slot0_q.s;
    // Only register writes wait on the port; branches and no-write entries always drain.
    assign commit       = head_valid & (~rf_we | rf_ready);
    assign taken        = commit & slot0_q.branch & slot0_q.e;
    assign accept       = in_valid & in_ready;
    assign branch_taken = taken;
    assign branch_pc    = taken ? slot0_q.target : '0;
    assign flag_c       = flag_c_q;
    assign flag_z       = flag_z_q;
    assign retire_count = retire_q;

    always_comb begin
        in_ent        = '0;
        in_ent.s      = in_s;
        in_ent.cout   = in_cout;
        in_ent.e      = in_e;
        in_ent.op     = in_op;
        in_ent.wb     = in_wb;
        in_ent.dest   = in_dest;
        in_ent.branch = in_branch;
        in_ent.target = in_target;
    end

    always_comb begin
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        count_d  = count_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        retire_d = retire_q;

        // A taken branch flushes the younger entry and anything arriving this edge.
        if (taken) begin
            count_d = '0;
        end else if (commit && accept) begin
            slot0_d = in_ent;
        end else if (commit) begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
        end else if (accept) begin
            if (count_q == 2'd0) begin
                slot0_d = in_ent;
            end else begin
                slot1_d = in_ent;
            end
            count_d = count_q + 2'd1;
        end

        if (commit) begin
            retire_d = retire_q + 16'd1;
            if (!slot0_q.branch) begin
                flag_z_d = (slot0_q.s == 20'd0);
                flag_c_d = (slot0_q.op == 3'b000 || slot0_q.op == 3'b001) ? slot0_q.cout : 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q  <= '0;
            slot1_q  <= '0;
            count_q  <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            retire_q <= '0;
        end else begin
            slot0_q  <= slot0_d;
            slot1_q  <= slot1_d;
            count_q  <= count_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
            retire_q <= retire_d;
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed-vector bench for alu_writeback_stage with hand-computed expectations.
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_s;
    logic        in_cout;
    logic        in_e;
    logic [2:0]  in_op;
    logic        in_wb;
    logic [3:0]  in_dest;
    logic        in_branch;
    logic [19:0] in_target;
    logic        rf_ready;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [19:0] rf_wdata;
    logic        flag_c;
    logic        flag_z;
    logic        branch_taken;
    logic [19:0] branch_pc;
    logic [15:0] retire_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    alu_writeback_stage #(.DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_s         (in_s),
        .in_cout      (in_cout),
        .in_e         (in_e),
        .in_op        (in_op),
        .in_wb        (in_wb),
        .in_dest      (in_dest),
        .in_branch    (in_branch),
        .in_target    (in_target),
        .rf_ready     (rf_ready),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .flag_c       (flag_c),
        .flag_z       (flag_z),
        .branch_taken (branch_taken),
        .branch_pc    (branch_pc),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [19:0] s, input logic cout, input logic e,
                           input logic [2:0] op, input logic wb, input logic [3:0] dest,
                           input logic br, input logic [19:0] tgt);
        in_valid  = 1'b1;
        in_s      = s;
        in_cout   = cout;
        in_e      = e;
        in_op     = op;
        in_wb     = wb;
        in_dest   = dest;
        in_branch = br;
        in_target = tgt;
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        #1;
    endtask

    // Accept then commit one entry with rf_ready held high.
    task automatic send_one(input logic [19:0] s, input logic cout, input logic [2:0] op,
                            input logic wb, input logic [3:0] dest);
        present(s, cout, 1'b0, op, wb, dest, 1'b0, 20'h0);
        tick();
        idle();
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_rf_we"}, 32'(rf_we), 32'd0);
        check({tag, "_rf_waddr"}, 32'(rf_waddr), 32'd0);
        check({tag, "_rf_wdata"}, 32'(rf_wdata), 32'd0);
        check({tag, "_flag_c"}, 32'(flag_c), 32'd0);
        check({tag, "_flag_z"}, 32'(flag_z), 32'd0);
        check({tag, "_br_taken"}, 32'(branch_taken), 32'd0);
        check({tag, "_br_pc"}, 32'(branch_pc), 32'd0);
        check({tag, "_retire"}, 32'(retire_count), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rf_ready = 1'b1;
        in_valid = 1'b0;
        in_s = '0; in_cout = 1'b0; in_e = 1'b0; in_op = '0;
        in_wb = 1'b0; in_dest = '0; in_branch = 1'b0; in_target = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_reset_values("rst");

        // Single add producing zero with carry
        present(20'h00000, 1'b1, 1'b0, 3'b000, 1'b1, 4'd3, 1'b0, 20'h0);
        tick();
        idle();
        check("add_we", 32'(rf_we), 32'd1);
        check("add_waddr", 32'(rf_waddr), 32'd3);
        check("add_wdata", 32'(rf_wdata), 32'h0);
        tick();
        check("add_z", 32'(flag_z), 32'd1);
        check("add_c", 32'(flag_c), 32'd1);
        check("add_retire", 32'(retire_count), 32'd1);
        check("add_we_after", 32'(rf_we), 32'd0);

        // Back-pressure: three entries while the write port is busy
        rf_ready = 1'b0;
        present(20'h11111, 1'b0, 1'b0, 3'b000, 1'b1, 4'd1, 1'b0, 20'h0);
        tick();
        present(20'h22222, 1'b0, 1'b0, 3'b000, 1'b1, 4'd2, 1'b0, 20'h0);
        check("bp_rdy1", 32'(in_ready), 32'd1);
        check("bp_we1", 32'(rf_we), 32'd1);
        check("bp_waddr1", 32'(rf_waddr), 32'd1);
        tick();
        present(20'h33333, 1'b0, 1'b0, 3'b000, 1'b1, 4'd4, 1'b0, 20'h0);
        check("bp_rdy_full", 32'(in_ready), 32'd0);
        check("bp_wdata_hold", 32'(rf_wdata), 32'h11111);
        tick();
        check("bp_rdy_full2", 32'(in_ready), 32'd0);
        check("bp_waddr_hold", 32'(rf_waddr), 32'd1);
        check("bp_retire_hold", 32'(retire_count), 32'd1);
        rf_ready = 1'b1;
        #1;
        tick();
        check("bp_head2_addr", 32'(rf_waddr), 32'd2);
        check("bp_head2_data", 32'(rf_wdata), 32'h22222);
        check("bp_rdy_after", 32'(in_ready), 32'd1);
        check("bp_retire_a", 32'(retire_count), 32'd2);
        tick();
        idle();
        check("bp_head3_addr", 32'(rf_waddr), 32'd4);
        check("bp_head3_data", 32'(rf_wdata), 32'h33333);
        check("bp_head3_we", 32'(rf_we), 32'd1);
        tick();
        check("bp_we_done", 32'(rf_we), 32'd0);
        check("bp_retire", 32'(retire_count), 32'd4);
        check("bp_z", 32'(flag_z), 32'd0);
        check("bp_c", 32'(flag_c), 32'd0);

        // Logic ops clear carry, including the unused op codes
        send_one(20'h00001, 1'b1, 3'b000, 1'b1, 4'd5);
        check("lc_set_c", 32'(flag_c), 32'd1);
        send_one(20'h00005, 1'b1, 3'b010, 1'b1, 4'd6);
        check("lc_and_c", 32'(flag_c), 32'd0);
        check("lc_and_z", 32'(flag_z), 32'd0);
        send_one(20'h00000, 1'b1, 3'b001, 1'b1, 4'd7);
        check("lc_sub_c", 32'(flag_c), 32'd1);
        check("lc_sub_z", 32'(flag_z), 32'd1);
        send_one(20'h00007, 1'b1, 3'b111, 1'b1, 4'd8);
        check("lc_op7_c", 32'(flag_c), 32'd0);
        check("lc_op7_z", 32'(flag_z), 32'd0);
        check("lc_retire", 32'(retire_count), 32'd8);

        // Taken branch; entry offered on the commit edge is discarded
        present(20'h00000, 1'b1, 1'b1, 3'b001, 1'b0, 4'd0, 1'b1, 20'h00400);
        tick();
        present(20'h99999, 1'b1, 1'b0, 3'b000, 1'b1, 4'd9, 1'b0, 20'h0);
        check("tk_pulse", 32'(branch_taken), 32'd1);
        check("tk_pc", 32'(branch_pc), 32'h00400);
        check("tk_we", 32'(rf_we), 32'd0);
        tick();
        idle();
        check("tk_pulse_off", 32'(branch_taken), 32'd0);
        check("tk_squash_we", 32'(rf_we), 32'd0);
        check("tk_empty", 32'(in_ready), 32'd1);
        check("tk_retire", 32'(retire_count), 32'd9);
        check("tk_z_keep", 32'(flag_z), 32'd0);
        check("tk_c_keep", 32'(flag_c), 32'd0);
        tick();
        check("tk_squash_we2", 32'(rf_we), 32'd0);
        check("tk_retire2", 32'(retire_count), 32'd9);

        // Not-taken branch followed by a normal write
        present(20'h00000, 1'b1, 1'b0, 3'b000, 1'b0, 4'd0, 1'b1, 20'h00123);
        tick();
        present(20'hABCDE, 1'b1, 1'b0, 3'b000, 1'b1, 4'd11, 1'b0, 20'h0);
        check("nt_pulse", 32'(branch_taken), 32'd0);
        check("nt_pc", 32'(branch_pc), 32'd0);
        tick();
        idle();
        check("nt_we", 32'(rf_we), 32'd1);
        check("nt_waddr", 32'(rf_waddr), 32'd11);
        check("nt_wdata", 32'(rf_wdata), 32'hABCDE);
        check("nt_z_keep", 32'(flag_z), 32'd0);
        check("nt_c_keep", 32'(flag_c), 32'd0);
        check("nt_retire_br", 32'(retire_count), 32'd10);
        tick();
        check("nt_retire", 32'(retire_count), 32'd11);
        check("nt_c", 32'(flag_c), 32'd1);

        // No-write entry drains even with the port busy
        rf_ready = 1'b0;
        send_one(20'h00000, 1'b0, 3'b001, 1'b0, 4'd2);
        check("nw_we", 32'(rf_we), 32'd0);
        check("nw_retire", 32'(retire_count), 32'd12);
        check("nw_z", 32'(flag_z), 32'd1);
        check("nw_c", 32'(flag_c), 32'd0);
        rf_ready = 1'b1;

        // Stream to 16'hFFFF, then one more commit wraps to zero
        present(20'h00001, 1'b0, 1'b0, 3'b010, 1'b1, 4'd1, 1'b0, 20'h0);
        for (int unsigned i = 0; i < 32'hFFFF - 12; i++) tick();
        idle();
        tick();
        check("wr_max", 32'(retire_count), 32'hFFFF);
        send_one(20'h00002, 1'b0, 3'b000, 1'b1, 4'd3);
        check("wr_wrap", 32'(retire_count), 32'd0);

        // Reset with two queued entries
        rf_ready = 1'b0;
        present(20'h12345, 1'b1, 1'b0, 3'b000, 1'b1, 4'd12, 1'b0, 20'h0);
        tick();
        present(20'h00000, 1'b1, 1'b0, 3'b000, 1'b1, 4'd13, 1'b0, 20'h0);
        tick();
        idle();
        check("mr_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        rf_ready = 1'b1;
        #1;
        tick();
        check_reset_values("mr_rst");
        rst = 1'b0;
        #1;
        tick();
        check_reset_values("mr_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
# alu_writeback_stage

Downstream consumer of the 20-bit ALU: it accepts each ALU result with its destination and control tag and buffers it in a 2-entry queue. It commits entries in order to the register-file write port, maintains the architectural carry/zero flags, and resolves equality branches from the ALU `e` output. It sits between the execute stage and the register file / fetch redirect logic, and absorbs write-port back-pressure without stalling the ALU for more than the queue depth.

## Interface
Parameters:
- `DEPTH`, 2: queue entries; only 2 is supported.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  execute stage presents an entry
- `in_ready`  out  1  stage can accept; `in_valid && in_ready` at a rising edge = accept
- `in_s`  in  20  ALU result `s`
- `in_cout`  in  1  ALU carry/borrow (already 0 for logic ops)
- `in_e`  in  1  ALU equality-compare output (already polarity-adjusted by BEQ/BNE select)
- `in_op`  in  3  ALU op code: 000 add, 001 sub, 010 and, 011 or, 100 xor
- `in_wb`  in  1  entry writes `in_s` to the register file
- `in_dest`  in  4  destination register index
- `in_branch`  in  1  entry is a conditional branch
- `in_target`  in  20  branch target address
- `rf_ready`  in  1  register-file write port free this cycle
- `rf_we`  out  1  write request (head valid, `wb=1`, not squashed)
- `rf_waddr`  out  4  head `dest`
- `rf_wdata`  out  20  head `s`
- `flag_c`  out  1  architectural carry flag
- `flag_z`  out  1  architectural zero flag
- `branch_taken`  out  1  one-cycle redirect pulse
- `branch_pc`  out  20  redirect target; valid when `branch_taken=1`
- `retire_count`  out  16  count of committed entries, wraps

## Operation
- Queue: 2-entry in-order FIFO with registered occupancy `count` (0..2). `in_ready = (count < 2)`, registered-only. There is no pass-through, so a full queue refuses input even if the head commits in the same cycle.
- Head commit condition, evaluated every cycle with head valid:
  - `wb=1` and not a branch: commit iff `rf_ready`.
  - Branch, or `wb=0`: commit unconditionally.
- `rf_we`, `rf_waddr`, `rf_wdata` are driven combinationally from the registered head. `rf_we` is high only for a valid head with `wb=1` and `branch=0`. The write takes effect on the edge where `rf_we && rf_ready`.
- Flags update on commit of a non-branch entry only:
  - `flag_z <= (s == 20'd0)`.
  - `flag_c <= cout` when `op` is 000 or 001; otherwise `flag_c <= 0`.
  - Branch entries leave the flags unchanged.
- Branch resolution on commit of a branch entry:
  - If `e=1`: `branch_taken` pulses high for exactly the commit cycle and `branch_pc = target`.
  - If `e=0`: no pulse.
  - A taken branch squashes any younger entry already in the queue. After the edge, `count = 0` and the squashed entry produces no write, flag update or retire.
  - An entry accepted on the same edge as a taken-branch commit is also discarded.
- `retire_count` increments by 1 on every commit, whether write, no-write or branch, taken or not. It wraps from 16'hFFFF to 0. Squashed entries are not counted.
- Simultaneous accept and commit with `count=1`: `count` stays 1 and the new entry becomes the head.
- Op codes 101..111 are treated as logic ops for the flag rules (`flag_c <= 0`).

## Timing
- Reset, taking priority over everything: `count=0`, `in_ready=1` from the first cycle after the reset edge. `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `flag_c=0`, `flag_z=0`, `branch_taken=0`, `branch_pc=0`, `retire_count=0`.
- Reset mid-operation drops all queued entries with no writes issued.
- Latency: an entry accepted at edge N is the head during cycle N+1 (when the queue was empty). With `rf_ready=1` it writes at edge N+1, and the flags and `retire_count` are visible in cycle N+2.
- Throughput: 1 entry per cycle while `rf_ready=1`.
- `rf_ready=0` holds the head with `rf_we` asserted and its outputs stable. A second entry may be accepted, after which `in_ready=0`.
- `branch_taken` is never high for two consecutive cycles from the same entry.

## Test plan
- Reset then single add: `s=20'h00000`, `cout=1`, `op=000`, `wb=1`, `dest=3`, `rf_ready=1` -> `rf_we=1`, `rf_waddr=3`, `rf_wdata=0` the cycle after accept. Next cycle `flag_z=1`, `flag_c=1`, `retire_count=1`.
- Back-pressure: hold `rf_ready=0` and present 3 back-to-back entries -> first two accepted, `in_ready=0` on the third. Head outputs stay stable. Release `rf_ready` -> writes in order, third entry accepted one cycle after the first commit.
- Logic op clears carry: set `flag_c=1` via an add, then commit `op=010` with `cout=1` and `s=20'h00005` -> `flag_c=0`, `flag_z=0`.
- Taken branch squash: queue a branch with `e=1`, `target=20'h00400`, followed by a `wb` entry -> `branch_taken` pulses 1 cycle with `branch_pc=20'h00400`. No `rf_we` for the younger entry, `retire_count` advances by 1, `count=0`.
- Not-taken branch: `e=0` -> no pulse, flags unchanged, the following `wb` entry commits normally.
- Wrap and reset: preload 65535 commits, commit one more -> `retire_count=0`. Then assert `rst` with 2 entries queued -> no writes issued, all outputs at their reset values.
